// File: rtl/pdp8_pkg.sv
// Shared PDP-8 memory-subsystem constants and the responder state type.
package pdp8_pkg;

    localparam int unsigned ADDR_WIDTH = 12;
    localparam int unsigned DATA_WIDTH = 12;
    localparam int unsigned MEM_DEPTH  = 4096;
    localparam int unsigned CNT_WIDTH  = 16;

    localparam logic [ADDR_WIDTH-1:0] START_ADDRESS = 12'o200;

    typedef enum logic {
        MEM_LOAD,
        MEM_RUN
    } mem_state_e;

endpackage

// File: rtl/pdp8_ram_1w2r.sv
// Word store with one write port and two registered read ports.
// A read of the address being written in the same cycle returns the new word.
module pdp8_ram_1w2r #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned MEM_DEPTH  = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_a_en,
    input  logic [ADDR_WIDTH-1:0] rd_a_addr,
    output logic [DATA_WIDTH-1:0] rd_a_data,
    output logic                  rd_a_valid,
    input  logic                  rd_b_en,
    input  logic [ADDR_WIDTH-1:0] rd_b_addr,
    output logic [DATA_WIDTH-1:0] rd_b_data,
    output logic                  rd_b_valid
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [DATA_WIDTH-1:0] rd_a_word;
    logic [DATA_WIDTH-1:0] rd_b_word;
    logic [DATA_WIDTH-1:0] rd_a_data_q;
    logic [DATA_WIDTH-1:0] rd_b_data_q;
    logic                  rd_a_valid_q;
    logic                  rd_b_valid_q;

    // Storage is deliberately not reset so a preload survives a core reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_a_word = mem[rd_a_addr];
        rd_b_word = mem[rd_b_addr];
        if (wr_en && (wr_addr == rd_a_addr)) begin
            rd_a_word = wr_data;
        end
        if (wr_en && (wr_addr == rd_b_addr)) begin
            rd_b_word = wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_a_data_q  <= '0;
            rd_b_data_q  <= '0;
            rd_a_valid_q <= 1'b0;
            rd_b_valid_q <= 1'b0;
        end else begin
            rd_a_valid_q <= rd_a_en;
            rd_b_valid_q <= rd_b_en;
            if (rd_a_en) begin
                rd_a_data_q <= rd_a_word;
            end
            if (rd_b_en) begin
                rd_b_data_q <= rd_b_word;
            end
        end
    end

    assign rd_a_data  = rd_a_data_q;
    assign rd_a_valid = rd_a_valid_q;
    assign rd_b_data  = rd_b_data_q;
    assign rd_b_valid = rd_b_valid_q;

endmodule

// File: rtl/pdp8_imem_responder.sv
// Main-memory responder: accepts a preload in LOAD, then serves the fetch and
// execution-unit ports in RUN until reset.
module pdp8_imem_responder
    import pdp8_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH_P = ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH_P = DATA_WIDTH,
    parameter int unsigned MEM_DEPTH_P  = MEM_DEPTH,
    parameter int unsigned CNT_WIDTH_P  = CNT_WIDTH,
    parameter logic [ADDR_WIDTH_P-1:0] START_ADDRESS_P = START_ADDRESS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ld_valid,
    input  logic [ADDR_WIDTH_P-1:0] ld_addr,
    input  logic [DATA_WIDTH_P-1:0] ld_data,
    input  logic                    ld_done,
    output logic                    mem_ready,
    output logic [ADDR_WIDTH_P-1:0] start_addr,
    input  logic                    ifu_rd_req,
    input  logic [ADDR_WIDTH_P-1:0] ifu_rd_addr,
    output logic [DATA_WIDTH_P-1:0] ifu_rd_data,
    output logic                    ifu_rd_valid,
    input  logic                    exec_rd_req,
    input  logic [ADDR_WIDTH_P-1:0] exec_rd_addr,
    output logic [DATA_WIDTH_P-1:0] exec_rd_data,
    output logic                    exec_rd_valid,
    input  logic                    exec_wr_req,
    input  logic [ADDR_WIDTH_P-1:0] exec_wr_addr,
    input  logic [DATA_WIDTH_P-1:0] exec_wr_data,
    output logic                    access_err,
    output logic [CNT_WIDTH_P-1:0]  fetch_cnt
);

    mem_state_e state_q, state_d;

    logic                    err_q, err_d;
    logic [CNT_WIDTH_P-1:0]  fetch_cnt_q, fetch_cnt_d;
    logic                    wr_en;
    logic [ADDR_WIDTH_P-1:0] wr_addr;
    logic [DATA_WIDTH_P-1:0] wr_data;
    logic                    ifu_en;
    logic                    exec_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= MEM_LOAD;
            err_q       <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // The single write port belongs to the loader in LOAD and to EXEC in RUN;
    // any access not owned by the current state is flagged instead of served.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = ld_addr;
        wr_data = ld_data;
        ifu_en  = 1'b0;
        exec_en = 1'b0;
        case (state_q)
            MEM_LOAD: begin
                wr_en = ld_valid;
                err_d = ifu_rd_req | exec_rd_req | exec_wr_req;
                if (ld_done) begin
                    state_d = MEM_RUN;
                end
            end
            MEM_RUN: begin
                wr_en   = exec_wr_req;
                wr_addr = exec_wr_addr;
                wr_data = exec_wr_data;
                ifu_en  = ifu_rd_req;
                exec_en = exec_rd_req;
                err_d   = ld_valid;
            end
            default: begin
                state_d = MEM_LOAD;
            end
        endcase
    end

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (ifu_en && (fetch_cnt_q != {CNT_WIDTH_P{1'b1}})) begin
            fetch_cnt_d = fetch_cnt_q + 1'b1;
        end
    end

    pdp8_ram_1w2r #(
        .ADDR_WIDTH (ADDR_WIDTH_P),
        .DATA_WIDTH (DATA_WIDTH_P),
        .MEM_DEPTH  (MEM_DEPTH_P)
    ) u_ram (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_a_en    (ifu_en),
        .rd_a_addr  (ifu_rd_addr),
        .rd_a_data  (ifu_rd_data),
        .rd_a_valid (ifu_rd_valid),
        .rd_b_en    (exec_en),
        .rd_b_addr  (exec_rd_addr),
        .rd_b_data  (exec_rd_data),
        .rd_b_valid (exec_rd_valid)
    );

    assign mem_ready  = (state_q == MEM_RUN);
    assign start_addr = mem_ready ? START_ADDRESS_P : '0;
    assign access_err = err_q;
    assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_pdp8_imem_responder.sv
// Scoreboard bench for pdp8_imem_responder: directed stimulus pushes expected
// read words and error pulses; a negedge monitor pops and compares them.
module tb_pdp8_imem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_valid = 1'b0;
    logic [11:0] ld_addr = '0;
    logic [11:0] ld_data = '0;
    logic        ld_done = 1'b0;
    logic        mem_ready;
    logic [11:0] start_addr;
    logic        ifu_rd_req = 1'b0;
    logic [11:0] ifu_rd_addr = '0;
    logic [11:0] ifu_rd_data;
    logic        ifu_rd_valid;
    logic        exec_rd_req = 1'b0;
    logic [11:0] exec_rd_addr = '0;
    logic [11:0] exec_rd_data;
    logic        exec_rd_valid;
    logic        exec_wr_req = 1'b0;
    logic [11:0] exec_wr_addr = '0;
    logic [11:0] exec_wr_data = '0;
    logic        access_err;
    logic [15:0] fetch_cnt;

    int errors = 0;
    int checks = 0;
    int pending_err = 0;
    logic [11:0] ifu_q[$];
    logic [11:0] exec_q[$];

    always #5 clk = ~clk;

    pdp8_imem_responder dut (
        .clk           (clk),
        .reset         (reset),
        .ld_valid      (ld_valid),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .ld_done       (ld_done),
        .mem_ready     (mem_ready),
        .start_addr    (start_addr),
        .ifu_rd_req    (ifu_rd_req),
        .ifu_rd_addr   (ifu_rd_addr),
        .ifu_rd_data   (ifu_rd_data),
        .ifu_rd_valid  (ifu_rd_valid),
        .exec_rd_req   (exec_rd_req),
        .exec_rd_addr  (exec_rd_addr),
        .exec_rd_data  (exec_rd_data),
        .exec_rd_valid (exec_rd_valid),
        .exec_wr_req   (exec_wr_req),
        .exec_wr_addr  (exec_wr_addr),
        .exec_wr_data  (exec_wr_data),
        .access_err    (access_err),
        .fetch_cnt     (fetch_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0o (octal) expected %0o (octal)", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ld_valid    = 1'b0;
        ld_done     = 1'b0;
        ifu_rd_req  = 1'b0;
        exec_rd_req = 1'b0;
        exec_wr_req = 1'b0;
    endtask

    task automatic preload(input logic [11:0] a, input logic [11:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        step();
        ld_valid = 1'b0;
    endtask

    task automatic ifu_read(input logic [11:0] a, input logic [11:0] exp);
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = a;
        ifu_q.push_back(exp);
    endtask

    task automatic exec_read(input logic [11:0] a, input logic [11:0] exp);
        exec_rd_req  = 1'b1;
        exec_rd_addr = a;
        exec_q.push_back(exp);
    endtask

    // Monitor: every valid or error pulse must match the head of its queue.
    initial begin
        forever begin
            @(negedge clk);
            if (ifu_rd_valid) begin
                check("ifu_valid_expected", 32'(ifu_q.size() > 0), 32'd1);
                if (ifu_q.size() > 0) check("ifu_rd_data", 32'(ifu_rd_data), 32'(ifu_q.pop_front()));
            end
            if (exec_rd_valid) begin
                check("exec_valid_expected", 32'(exec_q.size() > 0), 32'd1);
                if (exec_q.size() > 0) check("exec_rd_data", 32'(exec_rd_data), 32'(exec_q.pop_front()));
            end
            if (access_err) begin
                check("access_err_expected", 32'(pending_err > 0), 32'd1);
                if (pending_err > 0) pending_err--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        repeat (2) step();
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_start_addr", 32'(start_addr), 32'd0);
        check("rst_fetch_cnt", 32'(fetch_cnt), 32'd0);
        check("rst_ifu_rd_data", 32'(ifu_rd_data), 32'd0);
        check("rst_exec_rd_data", 32'(exec_rd_data), 32'd0);
        reset = 1'b0;
        step();

        preload(12'o0200, 12'o7200);
        preload(12'o0201, 12'o1205);
        preload(12'o7777, 12'o1234);
        preload(12'o0000, 12'o4567);

        // Accesses during LOAD are refused and flagged.
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = 12'o0200;
        pending_err++;
        step();
        ifu_rd_req = 1'b0;
        check("load_no_ifu_valid", 32'(ifu_rd_valid), 32'd0);
        check("load_err_pulse", 32'(access_err), 32'd1);
        step();
        check("load_err_once", 32'(access_err), 32'd0);
        exec_wr_req  = 1'b1;
        exec_wr_addr = 12'o0201;
        exec_wr_data = 12'o0000;
        pending_err++;
        step();
        exec_wr_req = 1'b0;
        check("load_mem_ready", 32'(mem_ready), 32'd0);

        // Final preload word together with ld_done.
        ld_valid = 1'b1;
        ld_done  = 1'b1;
        ld_addr  = 12'o0202;
        ld_data  = 12'o5200;
        step();
        clear_inputs();
        check("run_mem_ready", 32'(mem_ready), 32'd1);
        check("run_start_addr", 32'(start_addr), 32'o0200);

        ifu_read(12'o0200, 12'o7200);
        step();
        clear_inputs();
        check("fetch_valid_high", 32'(ifu_rd_valid), 32'd1);
        step();
        check("fetch_valid_one_cycle", 32'(ifu_rd_valid), 32'd0);
        check("fetch_data_holds", 32'(ifu_rd_data), 32'o7200);

        ifu_read(12'o0201, 12'o1205);
        exec_read(12'o0202, 12'o5200);
        step();
        clear_inputs();
        step();

        // Loader write in RUN is refused and memory is unchanged.
        ld_valid = 1'b1;
        ld_addr  = 12'o0200;
        ld_data  = 12'o0000;
        pending_err++;
        step();
        clear_inputs();
        step();
        check("run_err_once", 32'(access_err), 32'd0);
        ifu_read(12'o0200, 12'o7200);
        step();
        clear_inputs();

        // Write-first bypass on both read ports.
        exec_wr_req  = 1'b1;
        exec_wr_addr = 12'o0300;
        exec_wr_data = 12'o4321;
        ifu_read(12'o0300, 12'o4321);
        exec_read(12'o0300, 12'o4321);
        step();
        clear_inputs();
        step();
        check("fetch_cnt_4", 32'(fetch_cnt), 32'd4);

        // Back-to-back fetches at the address extremes.
        ifu_read(12'o7777, 12'o1234);
        step();
        ifu_read(12'o0000, 12'o4567);
        step();
        clear_inputs();
        step();
        check("fetch_cnt_6", 32'(fetch_cnt), 32'd6);

        force dut.fetch_cnt_q = 16'hFFFE;
        step();
        release dut.fetch_cnt_q;
        check("fetch_cnt_forced", 32'(fetch_cnt), 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            ifu_read(12'o0201, 12'o1205);
            step();
        end
        clear_inputs();
        step();
        check("fetch_cnt_saturated", 32'(fetch_cnt), 32'hFFFF);

        // Reset mid-RUN with a fetch pending: nothing comes out.
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = 12'o0200;
        reset       = 1'b1;
        step();
        check("rst2_ifu_valid", 32'(ifu_rd_valid), 32'd0);
        check("rst2_mem_ready", 32'(mem_ready), 32'd0);
        check("rst2_fetch_cnt", 32'(fetch_cnt), 32'd0);
        check("rst2_ifu_rd_data", 32'(ifu_rd_data), 32'd0);
        check("rst2_start_addr", 32'(start_addr), 32'd0);
        check("rst2_access_err", 32'(access_err), 32'd0);
        clear_inputs();
        reset = 1'b0;
        step();
        check("rst2_no_late_valid", 32'(ifu_rd_valid), 32'd0);
        ld_done = 1'b1;
        step();
        clear_inputs();
        check("rerun_mem_ready", 32'(mem_ready), 32'd1);
        ifu_read(12'o0200, 12'o7200);
        exec_read(12'o0300, 12'o4321);
        step();
        clear_inputs();
        repeat (3) step();

        check("ifu_queue_drained", 32'(ifu_q.size()), 32'd0);
        check("exec_queue_drained", 32'(exec_q.size()), 32'd0);
        check("err_pulses_seen", 32'(pending_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
